// File: rtl/stx_pll_cntr_reconfig_if.sv
// Host register bus for the PLL counter reconfiguration sequencer.
interface stx_pll_cntr_reconfig_if;
  logic        write;
  logic        read;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (output write, read, address, writedata, input readdata, readdatavalid);
  modport slave  (input write, read, address, writedata, output readdata, readdatavalid);
endinterface

// File: rtl/stx_pll_cntr_reconfig.sv
// Run-time reconfiguration sequencer for the M/N/C counter bank: shadow registers,
// active outputs, and a HOLD/WAIT sequence that reports done/locked.
module stx_pll_cntr_lane #(
  parameter logic [31:0] DEF_MODULUS = 32'd1,
  parameter logic [31:0] DEF_INITIAL = 32'd1,
  parameter logic [31:0] DEF_DELAY   = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        load,
  input  logic [1:0]  field,
  input  logic [31:0] wdata,
  output logic [31:0] sh_mod,
  output logic [31:0] sh_init,
  output logic [31:0] sh_dly,
  output logic [31:0] act_mod,
  output logic [31:0] act_init,
  output logic [31:0] act_dly
);
  logic [31:0] nxt_mod, nxt_init, nxt_dly;

  // Next shadow value is also the load source, so a write in the start cycle is applied.
  always_comb begin
    nxt_mod  = sh_mod;
    nxt_init = sh_init;
    nxt_dly  = sh_dly;
    if (wr_en) begin
      case (field)
        2'd0:    nxt_mod  = (wdata == '0) ? 32'd1 : wdata;
        2'd1:    nxt_init = wdata;
        2'd2:    nxt_dly  = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_mod   <= DEF_MODULUS;
      sh_init  <= DEF_INITIAL;
      sh_dly   <= DEF_DELAY;
      act_mod  <= DEF_MODULUS;
      act_init <= DEF_INITIAL;
      act_dly  <= DEF_DELAY;
    end else begin
      sh_mod  <= nxt_mod;
      sh_init <= nxt_init;
      sh_dly  <= nxt_dly;
      if (load) begin
        act_mod  <= nxt_mod;
        act_init <= nxt_init;
        act_dly  <= nxt_dly;
      end
    end
  end
endmodule

module stx_pll_cntr_reconfig #(
  parameter int          NUM_C        = 2,
  parameter int          RESET_CYCLES = 4,
  parameter int          LOCK_CYCLES  = 8,
  parameter logic [31:0] DEF_MODULUS  = 32'd1,
  parameter logic [31:0] DEF_INITIAL  = 32'd1,
  parameter logic [31:0] DEF_DELAY    = 32'd0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  stx_pll_cntr_reconfig_if.slave    bus,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      locked,
  output logic                      cntr_reset,
  output logic [(NUM_C+2)*32-1:0]   act_modulus,
  output logic [(NUM_C+2)*32-1:0]   act_initial,
  output logic [(NUM_C+2)*32-1:0]   act_delay
);
  localparam int NCNT = NUM_C + 2;
  localparam int MAXC = (RESET_CYCLES > LOCK_CYCLES) ? RESET_CYCLES : LOCK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WAIT} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2:0]             idx;
  logic [1:0]             field;
  logic                   load;
  logic [31:0]            rd_val;
  logic [NCNT-1:0][31:0]  sh_mod, sh_init, sh_dly;

  assign idx   = bus.address[4:2];
  assign field = bus.address[1:0];
  assign load  = (state == S_IDLE) && start;

  for (genvar i = 0; i < NCNT; i++) begin : g_lane
    stx_pll_cntr_lane #(
      .DEF_MODULUS (DEF_MODULUS),
      .DEF_INITIAL (DEF_INITIAL),
      .DEF_DELAY   (DEF_DELAY)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (bus.write && (idx == 3'(i))),
      .load     (load),
      .field    (field),
      .wdata    (bus.writedata),
      .sh_mod   (sh_mod[i]),
      .sh_init  (sh_init[i]),
      .sh_dly   (sh_dly[i]),
      .act_mod  (act_modulus[32*i +: 32]),
      .act_init (act_initial[32*i +: 32]),
      .act_dly  (act_delay[32*i +: 32])
    );
  end

  // Unmatched index or reserved field falls through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (idx == 3'(i)) begin
        case (field)
          2'd0:    rd_val = sh_mod[i];
          2'd1:    rd_val = sh_init[i];
          2'd2:    rd_val = sh_dly[i];
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) bus.readdata <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b1;
      cntr_reset <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state      <= S_HOLD;
          cnt        <= CW'(RESET_CYCLES - 1);
          busy       <= 1'b1;
          cntr_reset <= 1'b1;
          locked     <= 1'b0;
        end
        S_HOLD: if (cnt == '0) begin
          state      <= S_WAIT;
          cnt        <= CW'(LOCK_CYCLES - 1);
          cntr_reset <= 1'b0;
        end else begin
          cnt <= cnt - CW'(1);
        end
        S_WAIT: if (cnt == '0) begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          locked <= 1'b1;
          done   <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stx_pll_cntr_reconfig.sv
// Scoreboard bench: stimulus updates a register/sequence model and queues expected
// reads and done pulses; a negedge monitor compares everything the DUT presents.
module tb_stx_pll_cntr_reconfig;
  localparam int NUM_C = 2;
  localparam int RC    = 4;
  localparam int LC    = 8;
  localparam int NC    = NUM_C + 2;
  localparam int W     = NC * 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, locked, cntr_reset;
  logic [W-1:0] act_modulus, act_initial, act_delay;

  stx_pll_cntr_reconfig_if bus();

  stx_pll_cntr_reconfig #(
    .NUM_C(NUM_C), .RESET_CYCLES(RC), .LOCK_CYCLES(LC),
    .DEF_MODULUS(32'd1), .DEF_INITIAL(32'd1), .DEF_DELAY(32'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .locked      (locked),
    .cntr_reset  (cntr_reset),
    .act_modulus (act_modulus),
    .act_initial (act_initial),
    .act_delay   (act_delay)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: shadow/active tables and the start cycle of the running sequence.
  logic [31:0] sh  [NC][3];
  logic [31:0] act [NC][3];
  bit          seq_on;
  int          seq_t;

  typedef struct {int cyc; logic [31:0] val; logic [4:0] addr;} rd_t;
  rd_t rd_q[$];
  int  done_q[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, a, e);
  endtask

  function automatic bit in_seq(int c, int lo, int hi);
    return seq_on && (c >= seq_t + lo) && (c <= seq_t + hi);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      sh[i][0] = 32'd1; sh[i][1] = 32'd1; sh[i][2] = 32'd0;
      act[i][0] = 32'd1; act[i][1] = 32'd1; act[i][2] = 32'd0;
    end
    seq_on = 1'b0;
    seq_t  = 0;
    rd_q.delete();
    done_q.delete();
  endtask

  // Present one cycle of inputs, then fold their effect into the model at the edge.
  task automatic step(input bit w, input bit r, input logic [4:0] a, input logic [31:0] d, input bit s);
    int c, idx, fld;
    bit ok;
    logic [31:0] old;
    rd_t e;
    bus.write = w; bus.read = r; bus.address = a; bus.writedata = d; start = s;
    c   = cyc;
    idx = int'(a[4:2]);
    fld = int'(a[1:0]);
    ok  = (idx < NC) && (fld < 3);
    old = ok ? sh[idx][fld] : 32'd0;
    @(posedge clk);
    if (reset_n) begin
      if (r) begin e.cyc = c + 1; e.val = old; e.addr = a; rd_q.push_back(e); end
      if (w && ok) sh[idx][fld] = (fld == 0 && d == 0) ? 32'd1 : d;
      if (s && !in_seq(c, 1, RC + LC)) begin
        seq_on = 1'b1;
        seq_t  = c;
        done_q.push_back(c + RC + LC + 1);
        act = sh;
      end
    end
    #1;
    bus.write = 1'b0; bus.read = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Monitor: status/active vectors every cycle, reads and done against their queues.
  always @(negedge clk) begin
    logic [W-1:0] em, ei, ed;
    bit eb;
    rd_t e;
    for (int i = 0; i < NC; i++) begin
      em[32*i +: 32] = act[i][0];
      ei[32*i +: 32] = act[i][1];
      ed[32*i +: 32] = act[i][2];
    end
    eb = in_seq(cyc, 1, RC + LC);
    chk("busy", busy, eb);
    chk("locked", locked, !eb);
    chk("cntr_reset", cntr_reset, in_seq(cyc, 1, RC));
    chk("act_modulus", act_modulus, em);
    chk("act_initial", act_initial, ei);
    chk("act_delay", act_delay, ed);

    if (bus.readdatavalid) begin
      if (rd_q.size() == 0) chk("readdatavalid_spurious", bus.readdatavalid, 1'b0);
      else begin
        e = rd_q.pop_front();
        chk("read_cycle", cyc, e.cyc);
        chk($sformatf("readdata@%h", e.addr), bus.readdata, e.val);
      end
    end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
      e = rd_q.pop_front();
      chk("readdatavalid_missing", bus.readdatavalid, 1'b1);
    end

    if (done) begin
      if (done_q.size() == 0) chk("done_spurious", done, 1'b0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
      void'(done_q.pop_front());
      chk("done_missing", done, 1'b1);
    end
  end

  initial begin
    bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_readdatavalid", bus.readdatavalid, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset defaults read back
    step(1'b0, 1'b1, 5'h00, 32'd0, 1'b0);
    step(1'b0, 1'b1, 5'h01, 32'd0, 1'b0);
    step(1'b0, 1'b1, 5'h02, 32'd0, 1'b0);
    idle(2);

    // Basic reconfiguration with zero-modulus write-bypass on N in the start cycle
    step(1'b1, 1'b0, 5'h00, 32'd12, 1'b0);
    step(1'b1, 1'b0, 5'h08, 32'd6, 1'b0);
    step(1'b1, 1'b0, 5'h0A, 32'd250, 1'b0);
    step(1'b1, 1'b0, 5'h04, 32'd0, 1'b1);
    idle(5);
    // Start while busy (cycle T+6) together with a new M modulus
    step(1'b1, 1'b0, 5'h00, 32'd20, 1'b1);
    idle(8);
    step(1'b0, 1'b1, 5'h04, 32'd0, 1'b0);
    step(1'b0, 1'b0, 5'h00, 32'd0, 1'b1);
    idle(14);

    // Illegal addresses, plus read/write collision on a legal one
    step(1'b1, 1'b0, 5'h03, 32'hDEAD, 1'b0);
    step(1'b1, 1'b0, 5'h10, 32'hDEAD, 1'b0);
    step(1'b0, 1'b1, 5'h03, 32'd0, 1'b0);
    step(1'b0, 1'b1, 5'h10, 32'd0, 1'b0);
    step(1'b1, 1'b1, 5'h0D, 32'h55AA, 1'b0);
    step(1'b0, 1'b1, 5'h0D, 32'd0, 1'b0);
    step(1'b0, 1'b0, 5'h00, 32'd0, 1'b1);
    idle(14);

    // Asynchronous reset during HOLD (cycle T+3)
    step(1'b1, 1'b0, 5'h01, 32'd77, 1'b1);
    idle(2);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_cntr_reset", cntr_reset, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_locked", locked, 1'b1);
    chk("async_act_modulus", act_modulus, {NC{32'd1}});
    chk("async_act_initial", act_initial, {NC{32'd1}});
    chk("async_act_delay", act_delay, {W{1'b0}});
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1'b0, 1'b1, 5'h01, 32'd0, 1'b0);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4*NC - 1));
      d = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, $urandom_range(0, 9) == 0);
    end
    idle(RC + LC + 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
